// File: rtl/cdr_pkg.sv
// Shared constants and types for the 4x oversampling clock/data recovery block.
// Latency: none (declarations only).
// Backpressure: not applicable.
package cdr_pkg;
  localparam int OSR           = 4;
  localparam int WORD          = 32;
  localparam int BITS_PER_WORD = WORD / OSR;
  localparam int WIN_LOG2      = 4;
  localparam int MIN_TRANS     = 8;
  localparam int LOCK_WINDOWS  = 4;

  // Per-window accumulators hold up to 8 transitions x 2^WIN_LOG2 words.
  localparam int ACC_W = 4 + WIN_LOG2;
  // Sum of all four accumulators.
  localparam int TOT_W = ACC_W + 2;
  localparam int LCK_W = $clog2(LOCK_WINDOWS + 1);

  typedef logic [1:0]       phase_t;
  typedef logic [3:0]       bcnt_t;
  typedef logic [ACC_W-1:0] acc_t;
endpackage

// File: rtl/edge_hist.sv
// Counts sample-to-sample transitions of one word into four phase buckets.
// Latency: 1 cycle (stage A register).
// Backpressure: none; o_vld simply follows i_vld one cycle later.
module edge_hist
  import cdr_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WORD-1:0]        i_q,
  input  logic                   i_prev,
  input  logic                   i_vld,
  output bcnt_t [OSR-1:0]        o_cnt,
  output logic                   o_vld
);

  logic [WORD-1:0] w_trans;
  bcnt_t [OSR-1:0] w_cnt;
  bcnt_t [OSR-1:0] r_cnt;
  logic            r_vld;

  // s[-1] is the last sample of the previous valid word, so the word seam is counted too.
  assign w_trans = i_q ^ {i_q[WORD-2:0], i_prev};

  // Bucket p collects transitions at indices p, p+4, p+8, ...
  always_comb begin
    w_cnt = '0;
    for (int p = 0; p < OSR; p++) begin
      for (int j = 0; j < BITS_PER_WORD; j++) begin
        w_cnt[p] = w_cnt[p] + bcnt_t'(w_trans[j*OSR + p]);
      end
    end
  end

  // Stage A: register the bucket counts with their valid flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_vld <= 1'b0;
    end else begin
      r_vld <= i_vld;
      if (i_vld) r_cnt <= w_cnt;
    end
  end

  assign o_cnt = r_cnt;
  assign o_vld = r_vld;

endmodule

// File: rtl/oversample_cdr.sv
// Picks the 4x sampling phase farthest from the dominant edge and emits 8 bits per word.
// Latency: bits 1 cycle after q_vld; phase decision 2 cycles after the window's last word.
// Backpressure: none; q_vld gaps freeze sampling, history and window counting.
module oversample_cdr
  import cdr_pkg::*;
(
  input  logic                     pclk,
  input  logic                     reset,
  input  logic [WORD-1:0]          q_in,
  input  logic                     q_vld,
  output logic [BITS_PER_WORD-1:0] bits,
  output logic                     bits_vld,
  output phase_t                   phase,
  output logic                     locked,
  output logic                     phase_slip
);

  logic                     r_prev;
  logic [BITS_PER_WORD-1:0] r_bits;
  logic                     r_bits_vld;
  logic [BITS_PER_WORD-1:0] w_sel;
  logic [OSR-1:0]           w_grp;

  bcnt_t [OSR-1:0]          w_a_cnt;
  logic                     w_a_vld;

  acc_t [OSR-1:0]           r_acc;
  acc_t [OSR-1:0]           w_sum;
  acc_t [OSR-1:0]           r_dec_acc;
  logic                     r_dec_vld;
  logic [WIN_LOG2-1:0]      r_wcnt;

  logic [TOT_W-1:0]         w_total;
  acc_t                     w_best;
  phase_t                   w_edge;
  phase_t                   w_new_phase;

  phase_t                   r_phase;
  logic                     r_locked;
  logic                     r_slip;
  logic [LCK_W-1:0]         r_lock_cnt;

  edge_hist u_edge_hist (
    .clk    (pclk),
    .reset  (reset),
    .i_q    (q_in),
    .i_prev (r_prev),
    .i_vld  (q_vld),
    .o_cnt  (w_a_cnt),
    .o_vld  (w_a_vld)
  );

  // Remember the last sample of the previous valid word for seam transitions.
  always_ff @(posedge pclk) begin
    if (reset)      r_prev <= 1'b0;
    else if (q_vld) r_prev <= q_in[WORD-1];
  end

  // Select sample 4k+phase from each group of four.
  always_comb begin
    w_sel = '0;
    w_grp = '0;
    for (int k = 0; k < BITS_PER_WORD; k++) begin
      w_grp    = q_in[k*OSR +: OSR];
      w_sel[k] = w_grp[r_phase];
    end
  end

  // Register recovered bits; they hold across q_vld gaps.
  always_ff @(posedge pclk) begin
    if (reset) begin
      r_bits     <= '0;
      r_bits_vld <= 1'b0;
    end else begin
      r_bits_vld <= q_vld;
      if (q_vld) r_bits <= w_sel;
    end
  end

  // Running window sums including the word currently in stage A.
  always_comb begin
    w_sum = '0;
    for (int p = 0; p < OSR; p++) begin
      w_sum[p] = r_acc[p] + acc_t'(w_a_cnt[p]);
    end
  end

  // Stage B: accumulate; on the last word of a window hand the sums off and restart from zero.
  always_ff @(posedge pclk) begin
    if (reset) begin
      r_acc     <= '0;
      r_dec_acc <= '0;
      r_dec_vld <= 1'b0;
      r_wcnt    <= '0;
    end else begin
      r_dec_vld <= 1'b0;
      if (w_a_vld) begin
        r_wcnt <= r_wcnt + 1'b1;
        if (r_wcnt == '1) begin
          r_dec_acc <= w_sum;
          r_dec_vld <= 1'b1;
          r_acc     <= '0;
        end else begin
          r_acc <= w_sum;
        end
      end
    end
  end

  // Dominant edge bucket (lowest index wins ties) and total transition count.
  always_comb begin
    w_total = '0;
    w_best  = r_dec_acc[0];
    w_edge  = '0;
    for (int p = 0; p < OSR; p++) begin
      w_total = w_total + TOT_W'(r_dec_acc[p]);
    end
    for (int p = 1; p < OSR; p++) begin
      if (r_dec_acc[p] > w_best) begin
        w_best = r_dec_acc[p];
        w_edge = phase_t'(p);
      end
    end
  end

  assign w_new_phase = w_edge + 2'd2;

  // Phase decision and lock tracking; sparse windows leave everything untouched.
  always_ff @(posedge pclk) begin
    if (reset) begin
      r_phase    <= 2'd2;
      r_locked   <= 1'b0;
      r_slip     <= 1'b0;
      r_lock_cnt <= '0;
    end else begin
      r_slip <= 1'b0;
      if (r_dec_vld && (w_total >= TOT_W'(MIN_TRANS))) begin
        if (w_new_phase == r_phase) begin
          if (r_lock_cnt < LCK_W'(LOCK_WINDOWS)) r_lock_cnt <= r_lock_cnt + 1'b1;
          if (r_lock_cnt >= LCK_W'(LOCK_WINDOWS - 1)) r_locked <= 1'b1;
        end else begin
          r_phase    <= w_new_phase;
          r_slip     <= 1'b1;
          r_locked   <= 1'b0;
          r_lock_cnt <= LCK_W'(1);
        end
      end
    end
  end

  assign bits       = r_bits;
  assign bits_vld   = r_bits_vld;
  assign phase      = r_phase;
  assign locked     = r_locked;
  assign phase_slip = r_slip;

endmodule

// File: tb/tb_oversample_cdr.sv
// Self-checking bench for oversample_cdr with a bit-level reference model and bits scoreboard.
// Latency: checks outputs 1 time unit after every rising edge.
// Backpressure: exercises q_vld gaps.
module tb_oversample_cdr;

  logic        pclk;
  logic        reset;
  logic [31:0] q_in;
  logic        q_vld;
  logic [7:0]  bits;
  logic        bits_vld;
  logic [1:0]  phase;
  logic        locked;
  logic        phase_slip;

  oversample_cdr dut (
    .pclk       (pclk),
    .reset      (reset),
    .q_in       (q_in),
    .q_vld      (q_vld),
    .bits       (bits),
    .bits_vld   (bits_vld),
    .phase      (phase),
    .locked     (locked),
    .phase_slip (phase_slip)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int n_checks = 0;
  int n_errors = 0;
  int n_slips  = 0;
  int cyc      = 0;

  // reference model state
  logic [7:0] sb[$];
  logic [7:0] m_last;
  int         m_phase, m_lock, m_locked, m_slip_exp;
  int         m_h[4];
  int         m_dec_h[4];
  int         m_wc, m_dec_at;
  logic       m_prev;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_last = 8'h00; m_phase = 2; m_lock = 0; m_locked = 0; m_slip_exp = 0;
    m_wc = 0; m_dec_at = -1; m_prev = 1'b0;
    for (int p = 0; p < 4; p++) begin m_h[p] = 0; m_dec_h[p] = 0; end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      q_vld = 1'b1;
      q_in  = $urandom;
      @(posedge pclk);
      #1;
      chk("rst_bits", bits, 0);
      chk("rst_bits_vld", bits_vld, 0);
      chk("rst_phase", phase, 2);
      chk("rst_locked", locked, 0);
      chk("rst_slip", phase_slip, 0);
      cyc++;
    end
    reset = 1'b0;
    model_reset();
    n_slips = 0;
    cyc     = 0;
  endtask

  task automatic step(input logic v, input logic [31:0] d);
    logic [7:0] eb;
    logic       sp;
    int         best, total;
    q_vld = v;
    q_in  = d;
    @(posedge pclk);
    // sampling uses the phase in effect before any decision at this edge
    if (v) begin
      for (int k = 0; k < 8; k++) eb[k] = d[4*k + m_phase];
      sb.push_back(eb);
      m_last = eb;
    end
    m_slip_exp = 0;
    if (cyc == m_dec_at) begin
      best = 0; total = 0;
      for (int p = 0; p < 4; p++) begin
        total += m_dec_h[p];
        if (m_dec_h[p] > m_dec_h[best]) best = p;
      end
      if (total >= 8) begin
        if ((best + 2) % 4 == m_phase) begin
          if (m_lock < 4) m_lock++;
          if (m_lock == 4) m_locked = 1;
        end else begin
          m_phase = (best + 2) % 4;
          m_slip_exp = 1;
          m_locked = 0;
          m_lock = 1;
        end
      end
    end
    if (v) begin
      for (int i = 0; i < 32; i++) begin
        sp = (i == 0) ? m_prev : d[i-1];
        if (d[i] != sp) m_h[i % 4]++;
      end
      m_prev = d[31];
      m_wc++;
      if (m_wc == 16) begin
        for (int p = 0; p < 4; p++) begin m_dec_h[p] = m_h[p]; m_h[p] = 0; end
        m_wc = 0;
        m_dec_at = cyc + 2;
      end
    end
    #1;
    chk("bits_vld", bits_vld, v);
    if (bits_vld) begin
      chk("sb_nonempty", sb.size() > 0, 1);
      if (sb.size() > 0) chk("bits", bits, sb.pop_front());
    end else begin
      chk("bits_hold", bits, m_last);
    end
    chk("phase", phase, m_phase);
    chk("locked", locked, m_locked);
    chk("phase_slip", phase_slip, m_slip_exp);
    if (phase_slip) n_slips++;
    cyc++;
  endtask

  initial begin
    reset = 1'b1;
    q_vld = 1'b0;
    q_in  = '0;
    model_reset();

    // reset with valid random input, then random words at phase 2
    do_reset(3);
    for (int i = 0; i < 5; i++) step(1'b1, $urandom);
    chk("q_after_random", sb.size(), 0);

    // edge-at-phase-1 stream: slip to 3, then lock on the 4th decision
    do_reset(1);
    for (int i = 0; i < 17; i++) step(1'b1, 32'h1E1E1E1E);
    chk("p1_no_slip_yet", n_slips, 0);
    step(1'b1, 32'h1E1E1E1E);
    chk("p1_slip_edge", n_slips, 1);
    chk("p1_phase3", phase, 3);
    chk("p1_bits55", bits, 8'h55);
    for (int i = 0; i < 65; i++) step(1'b1, 32'h1E1E1E1E);
    chk("p1_locked", locked, 1);
    chk("p1_slips", n_slips, 1);
    // random words sampled at phase 3, then idle cycles hold bits
    for (int i = 0; i < 4; i++) step(1'b1, $urandom);
    for (int i = 0; i < 20; i++) step(1'b1, 32'h1E1E1E1E);
    for (int i = 0; i < 4; i++) step(1'b0, $urandom);
    chk("p1_still_locked", locked, 1);

    // constant data: no decision ever counts
    do_reset(1);
    for (int i = 0; i < 64; i++) step(1'b1, 32'h0);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0);
    chk("zero_phase", phase, 2);
    chk("zero_slips", n_slips, 0);
    chk("zero_locked", locked, 0);
    chk("zero_bits", bits, 8'h00);

    // tie between buckets 0 and 2: edge 0 keeps phase 2 and locks without slipping
    do_reset(1);
    for (int i = 0; i < 67; i++) step(1'b1, 32'h30303030);
    chk("tie_phase", phase, 2);
    chk("tie_slips", n_slips, 0);
    chk("tie_locked", locked, 1);

    // q_vld gaps every other cycle
    do_reset(1);
    for (int i = 0; i < 40; i++) step(i % 2 == 0, 32'h1E1E1E1E);
    chk("gap_phase", phase, 3);
    chk("gap_slips", n_slips, 1);
    for (int i = 0; i < 40; i++) step(i % 3 != 0, $urandom_range(0, 1) ? 32'h1E1E1E1E : 32'h3C3C3C3C);

    // mid-window reset discards the partial histogram
    do_reset(1);
    for (int i = 0; i < 10; i++) step(1'b1, 32'h1E1E1E1E);
    do_reset(1);
    chk("mwr_phase", phase, 2);
    for (int i = 0; i < 17; i++) step(1'b1, 32'h1E1E1E1E);
    chk("mwr_no_early", n_slips, 0);
    step(1'b1, 32'h1E1E1E1E);
    chk("mwr_slip", n_slips, 1);
    chk("mwr_phase3", phase, 3);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0);

    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
